dp_rr_arbiter: RTL and testbench
================================

Name: dp_rr_arbiter

Overview:
Shares the single 8-bit registered datapath (the `dut` block, data_in -> data_out with fixed latency) between NUM_REQ requesters. It round-robin arbitrates valid/ready requests and issues at most one word per cycle into the datapath. It tracks the issuing requester's ID through a latency-matched tag pipeline and returns each datapath result with that ID. It sits between the requester-side ports and the `dut` instance.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 8, datapath word width
DP_LATENCY, 1, datapath clock cycles from dp_data_in sampled to dp_data_out valid (>=1)
ID_WIDTH, $clog2(NUM_REQ), requester ID width (derived localparam, not overridable)

Ports:
clk  in  1  system clock, all logic posedge
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_data  in  NUM_REQ*DATA_WIDTH  per-requester word; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i] at posedge
dp_data_in  out  DATA_WIDTH  to datapath data_in (registered)
dp_data_out  in  DATA_WIDTH  from datapath data_out
rsp_valid  out  1  result valid, single-cycle pulse per accepted request
rsp_id  out  ID_WIDTH  requester ID of result
rsp_data  out  DATA_WIDTH  datapath result
busy  out  1  high while any accepted request has no response yet

Behaviour:
- Reset (async assert, sync to clk release): dp_data_in=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, RR pointer=0, tag pipeline cleared. req_ready=0 while reset is high.
- Arbitration is combinational. Grant goes to the first requester with req_valid=1, searching from ptr upward with wrap mod NUM_REQ. req_ready is one-hot or zero, never multi-hot.
- Requester holds req_valid and req_data stable until accepted. The arbiter never grants a requester whose req_valid is low.
- On acceptance at edge T: ptr <= (granted+1) mod NUM_REQ, and dp_data_in <= granted word. With no acceptance, ptr is unchanged and dp_data_in <= 0 (bubble).
- Tag pipeline: {valid, id} shift register, depth DP_LATENCY+1; stage 0 is loaded at T.
- At edge T+1+DP_LATENCY: rsp_valid<=1, rsp_id<=tag id, rsp_data<=dp_data_out. Total latency is DP_LATENCY+1 edges (DP_LATENCY=1: result visible after edge T+2).
- Bubbles produce rsp_valid=0. rsp_id and rsp_data hold their last values when rsp_valid=0.
- No response backpressure. Full throughput is one accept and one response per cycle. Responses are in acceptance order.
- busy = OR of all tag-pipeline valid bits.
- Reset mid-operation: in-flight tags are discarded and no responses are emitted for them.
- Single requester asserting continuously: granted every cycle (pointer skips idle requesters).

Optional Feature:
Macro DP_ARB_STATS_EN.
- Defined: adds output port grant_count (NUM_REQ*16). It holds one 16-bit saturating counter per requester, incremented on each acceptance, held at 0xFFFF once reached, and cleared by reset.
- Undefined: port and counters absent; behaviour is otherwise identical.

Decomposition:
- Package dp_arb_pkg holds:
  - typedef tag_t: packed struct {logic valid; logic [ID_WIDTH-1:0] id;}
  - localparam CNT_WIDTH=16
  - a function for round-robin next-pointer computation
- One sub-module, rr_grant: combinational one-hot round-robin selector (req vector + ptr -> grant vector + grant index).

Test Plan:
- Reset with NUM_REQ=4, DP_LATENCY=1, datapath inverting: all outputs 0, req_ready=0 during reset.
- req0 data 0x3C, single request accepted at T -> rsp_valid pulse after T+2, rsp_id=0, rsp_data=0xC3. busy high from T to T+2 only.
- All four requesters valid simultaneously with data 0x00/0x11/0x22/0x33 -> grants 0,1,2,3 on consecutive cycles. Responses back-to-back with ids 0..3 and data 0xFF/0xEE/0xDD/0xCC.
- req1 and req3 held continuously for 6 cycles -> grants alternate 1,3,1,3,1,3. No response is dropped or reordered.
- Reset asserted while two requests are in flight -> no rsp_valid after release; ptr=0; a subsequent req2 of 0xA5 returns 0x5A with id 2.
- With DP_ARB_STATS_EN and 100 random requests plus edge values 0x00/0xFF -> every result equals the bitwise inverse of its input. grant_count sums to 102 and matches the per-ID response tally.

Source files
------------

// File: rtl/dp_arb_pkg.sv
// Shared types and helpers for the round-robin datapath arbiter (dp_rr_arbiter).
// DP_ARB_STATS_EN enables the per-requester grant counters in the top level.
package dp_arb_pkg;

  localparam int CNT_WIDTH    = 16;
  // Tag IDs are sized for the largest supported requester count (16).
  localparam int TAG_ID_WIDTH = 4;

  typedef struct packed {
    logic                    valid;
    logic [TAG_ID_WIDTH-1:0] id;
  } tag_t;

  // Pointer that follows a grant: one past the winner, wrapping at num_req.
  function automatic int rr_next_ptr(input int granted, input int num_req);
    int nxt;
    if (granted >= num_req - 1) begin
      nxt = 0;
    end else begin
      nxt = granted + 1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin selector: first asserted request at or above ptr,
// wrapping modulo NUM_REQ, reported as a one-hot vector plus its index.
module rr_grant #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_idx,
  output logic                grant_any
);

  // Scan from ptr upward; the first hit blocks all later candidates.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_WIDTH'(idx);
      end else begin
        grant_any = grant_any;
      end
    end
  end

endmodule

// File: rtl/dp_rr_arbiter.sv
// Round-robin front end for a shared fixed-latency datapath; returns each result
// tagged with its requester ID. Define DP_ARB_STATS_EN to add grant_count.
module dp_rr_arbiter
  import dp_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int DP_LATENCY = 1,
  localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         dp_data_in,
  input  logic [DATA_WIDTH-1:0]         dp_data_out,
  output logic                          rsp_valid,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          busy
`ifdef DP_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  grant_count
`endif
);

  logic [ID_WIDTH-1:0]   ptr;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic                  grant_any;
  logic                  accept;
  logic [DATA_WIDTH-1:0] grant_word;
  tag_t                  tag_pipe [DP_LATENCY+1];

  rr_grant #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_grant (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Grants only go to valid requesters, so any grant outside reset is a transfer.
  assign req_ready  = reset ? '0 : grant;
  assign accept     = grant_any & ~reset;
  assign grant_word = req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

  // Issue stage: pointer update, datapath word (zero bubble when idle) and tag shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      dp_data_in <= '0;
      for (int i = 0; i <= DP_LATENCY; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      if (accept) begin
        ptr         <= ID_WIDTH'(rr_next_ptr(int'(grant_idx), NUM_REQ));
        dp_data_in  <= grant_word;
        tag_pipe[0] <= '{valid: 1'b1, id: TAG_ID_WIDTH'(grant_idx)};
      end else begin
        ptr         <= ptr;
        dp_data_in  <= '0;
        tag_pipe[0] <= '0;
      end
      for (int i = 1; i <= DP_LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // Response stage: last tag stage lines up with the datapath result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else if (tag_pipe[DP_LATENCY].valid) begin
      rsp_valid <= 1'b1;
      rsp_id    <= ID_WIDTH'(tag_pipe[DP_LATENCY].id);
      rsp_data  <= dp_data_out;
    end else begin
      rsp_valid <= 1'b0;
      rsp_id    <= rsp_id;
      rsp_data  <= rsp_data;
    end
  end

  // Busy while any tag stage still carries an accepted request.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i <= DP_LATENCY; i++) begin
      busy = busy | tag_pipe[i].valid;
    end
  end

`ifdef DP_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
    logic [CNT_WIDTH-1:0] cnt;

    // Saturating per-requester acceptance counter.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= '0;
      end else if (accept && (grant_idx == ID_WIDTH'(g)) && (cnt != {CNT_WIDTH{1'b1}})) begin
        cnt <= cnt + CNT_WIDTH'(1);
      end else begin
        cnt <= cnt;
      end
    end

    assign grant_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt;
  end
`endif

endmodule

// File: tb/tb_dp_rr_arbiter.sv
// Scoreboard bench for dp_rr_arbiter with an inverting one-cycle datapath model.
// With DP_ARB_STATS_EN defined it also exercises grant_count.
module tb_dp_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  dp_data_in;
  logic [7:0]  dp_data_out;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        busy;
`ifdef DP_ARB_STATS_EN
  logic [63:0] grant_count;
`endif

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   tally[4];

  always #5 clk = ~clk;

  dp_rr_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .DP_LATENCY (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .dp_data_in  (dp_data_in),
    .dp_data_out (dp_data_out),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .busy        (busy)
`ifdef DP_ARB_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  // Datapath stand-in: registered bitwise inverse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dp_data_out <= 8'h00;
    else       dp_data_out <= ~dp_data_in;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest expected entry.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got id=%0d data=0x%0h, expected no response", rsp_id, rsp_data);
      end else begin
        mon_e = sbq.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
        tally[rsp_id]++;
      end
    end
  end

  task automatic reset_pulse();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  // One single-requester transfer with expected result pushed on issue.
  task automatic issue_one(input int id, input logic [7:0] d, input logic [7:0] exp_d);
    req_valid = 4'b0001 << id;
    req_data  = 32'(d) << (id * 8);
    sbq.push_back('{id: 2'(id), data: exp_d});
    @(negedge clk);
    chk("single_grant", 32'(req_ready), 32'(4'b0001 << id));
    @(posedge clk); #1;
    req_valid = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d1;
    logic [7:0] d3;
    for (int i = 0; i < 4; i++) tally[i] = 0;

    // Reset state, with requests pending during reset.
    reset     = 1'b1;
    req_valid = 4'hF;
    req_data  = 32'h33221100;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_dp_in", 32'(dp_data_in), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    req_valid = 4'h0;
    reset     = 1'b0;

    // Single request: latency and busy window.
    req_valid = 4'b0001;
    req_data  = 32'h0000003C;
    sbq.push_back('{id: 2'd0, data: 8'hC3});
    @(negedge clk);
    chk("t2_grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    chk("t2_dp_in", 32'(dp_data_in), 32'h3C);
    @(negedge clk);
    chk("t2_busy_t0", 32'(busy), 32'h1);
    chk("t2_rsp_t0", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    chk("t2_busy_t1", 32'(busy), 32'h1);
    chk("t2_rsp_t1", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    chk("t2_rsp_t2", 32'(rsp_valid), 32'h1);
    chk("t2_busy_t2", 32'(busy), 32'h0);
    @(negedge clk);
    chk("t2_rsp_pulse", 32'(rsp_valid), 32'h0);
    chk("t2_rsp_hold", 32'(rsp_data), 32'hC3);
    drain();

    // All four at once from pointer 0.
    reset_pulse();
    req_valid = 4'hF;
    req_data  = 32'h33221100;
    sbq.push_back('{id: 2'd0, data: 8'hFF});
    sbq.push_back('{id: 2'd1, data: 8'hEE});
    sbq.push_back('{id: 2'd2, data: 8'hDD});
    sbq.push_back('{id: 2'd3, data: 8'hCC});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_grant", 32'(req_ready), 32'(4'b0001 << k));
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
    end
    drain();

    // Requesters 1 and 3 held continuously: strict alternation.
    req_valid = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      d1 = 8'h10 + 8'(k);
      d3 = 8'h30 + 8'(k);
      req_data = {d3, 8'h00, d1, 8'h00};
      if (k % 2 == 0) sbq.push_back('{id: 2'd1, data: ~d1});
      else            sbq.push_back('{id: 2'd3, data: ~d3});
      @(negedge clk);
      chk("t4_grant", 32'(req_ready), (k % 2 == 0) ? 32'h2 : 32'h8);
      @(posedge clk); #1;
    end
    req_valid = 4'b0000;
    drain();

    // Reset with two requests in flight: no responses may follow.
    req_valid = 4'b0011;
    req_data  = 32'h00005544;
    @(negedge clk);
    chk("t5_grant0", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("t5_grant1", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    reset     = 1'b1;
    #1;
    chk("t5_busy_rst", 32'(busy), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("t5_ptr", 32'(dut.ptr), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_no_rsp", 32'(rsp_valid), 32'h0);
    end
    @(posedge clk); #1;
    issue_one(2, 8'hA5, 8'h5A);
    drain();

`ifdef DP_ARB_STATS_EN
    begin
      int issued[4];
      int id;
      int sum;
      logic [7:0] d;
      reset_pulse();
      for (int i = 0; i < 4; i++) begin
        tally[i]  = 0;
        issued[i] = 0;
      end
      for (int n = 0; n < 102; n++) begin
        id = $urandom_range(0, 3);
        if (n == 0)      d = 8'h00;
        else if (n == 1) d = 8'hFF;
        else             d = 8'($urandom_range(0, 255));
        issue_one(id, d, ~d);
        issued[id]++;
      end
      drain();
      sum = 0;
      for (int i = 0; i < 4; i++) begin
        sum += int'(grant_count[i*16 +: 16]);
        chk("stats_vs_tally", 32'(grant_count[i*16 +: 16]), 32'(tally[i]));
        chk("stats_vs_issued", 32'(grant_count[i*16 +: 16]), 32'(issued[i]));
      end
      chk("stats_sum", 32'(sum), 32'd102);
    end
`endif

    chk("sb_empty", 32'(sbq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
